wb_eic_slave: RTL and testbench

- Embedded Interrupt Controller (EIC) that acts as a Wishbone classic slave.
- Collects up to N_IRQ interrupt sources. Each source is rising-edge, falling-edge, level-high or level-low sensitive.
- Latches enabled events into a pending register (ISR) and drives a single wb_irq_o line to the host CPU.
- The host services interrupts through four word registers: IDR, IER, IMR and ISR.

---
 rtl/wb_eic_slave.sv | 68 ++++++
 tb/tb_wb_eic_slave.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/wb_eic_slave.sv
// wb_eic_slave: Wishbone classic slave interrupt controller with per-source
// edge/level sensing, IMR/ISR registers and a registered irq line.
module wb_eic_slave #(
  parameter int N_IRQ = 4,
  parameter logic [2*N_IRQ-1:0] IRQ_MODE = 8'b10_11_01_00
) (
  input  logic             wb_clk_i,
  input  logic             rst_n_i,
  input  logic [1:0]       wb_addr_i,
  input  logic [31:0]      wb_data_i,
  output logic [31:0]      wb_data_o,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [3:0]       wb_sel_i,
  output logic             wb_ack_o,
  output logic             wb_irq_o,
  input  logic [N_IRQ-1:0] irq_i
);
  function automatic logic [N_IRQ-1:0] mode_bit(input int b);
    mode_bit = '0;
    for (int k = 0; k < N_IRQ; k++) mode_bit[k] = IRQ_MODE[2*k+b];
  endfunction
  // low mode bit is the inactive level, high mode bit selects level sensing
  localparam logic [N_IRQ-1:0] INACT = mode_bit(0);
  localparam logic [N_IRQ-1:0] LEVEL = mode_bit(1);
  logic [N_IRQ-1:0] s1_q, s2_q, hist_q, imr_q, imr_d, isr_q, isr_d, ev, wd, clr;
  logic [31:0] bmask, data_d;
  logic acc, unused_ok;
  assign unused_ok = ^{wb_data_i, wb_sel_i};
  assign acc = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign bmask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign wd = N_IRQ'(wb_data_i & bmask);
  assign ev = (s2_q ^ INACT) & (LEVEL | (s2_q ^ hist_q));
  always_comb begin
    imr_d = imr_q;
    clr = '0;
    data_d = wb_data_o;
    if (acc) begin
      data_d = wb_we_i ? '0 : wb_addr_i == 2'd2 ? 32'(imr_q) : wb_addr_i == 2'd3 ? 32'(isr_q) : '0;
      if (wb_we_i) begin
        imr_d = wb_addr_i == 2'd0 ? imr_q & ~wd : wb_addr_i == 2'd1 ? imr_q | wd : imr_q;
        clr = wb_addr_i == 2'd3 ? wd : '0;
      end
    end
    isr_d = (isr_q & ~clr) | (ev & imr_q);
  end
  always_ff @(posedge wb_clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      s1_q <= INACT;
      s2_q <= INACT;
      hist_q <= INACT;
      imr_q <= '0;
      isr_q <= '0;
      wb_data_o <= '0;
      wb_ack_o <= 1'b0;
      wb_irq_o <= 1'b0;
    end else begin
      s1_q <= irq_i;
      s2_q <= s1_q;
      hist_q <= s2_q;
      imr_q <= imr_d;
      isr_q <= isr_d;
      wb_data_o <= data_d;
      wb_ack_o <= acc;
      wb_irq_o <= |(isr_q & imr_q);
    end
endmodule

// File: tb/tb_wb_eic_slave.sv
// tb_wb_eic_slave: table-driven bus/irq vectors plus hand-written latency,
// ack, set/clear race and mid-access reset sequences.
module tb_wb_eic_slave;
  localparam logic [1:0] IDR = 2'd0, IER = 2'd1, IMR = 2'd2, ISR = 2'd3;
  logic clk = 1'b0, rst_n, cyc, stb, we, ack, irq_o;
  logic [1:0] addr;
  logic [31:0] wdat, rdat, rd;
  logic [3:0] sel, irq;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic we;
    logic [1:0] a;
    logic [31:0] d;
    logic [3:0] s;
    logic [3:0] irq;
    int w;
    logic eirq;
    logic [31:0] erd;
  } vec_t;
  vec_t tv[$];
  wb_eic_slave dut (
    .wb_clk_i(clk), .rst_n_i(rst_n), .wb_addr_i(addr), .wb_data_i(wdat),
    .wb_data_o(rdat), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_ack_o(ack), .wb_irq_o(irq_o), .irq_i(irq)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] r);
    int n = 0;
    @(negedge clk);
    cyc = 1; stb = 1; we = w; addr = a; wdat = d; sel = s;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack && n < 10);
    chk("ack", {31'b0, ack}, 1);
    r = rdat;
    cyc = 0; stb = 0; we = 0;
    @(posedge clk); #1;
    chk("ack_drop", {31'b0, ack}, 0);
  endtask
  task automatic add(input logic w, input logic [1:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic [3:0] q, input int n, input logic ei, input logic [31:0] er);
    tv.push_back('{w, a, d, s, q, n, ei, er});
  endtask
  initial begin
    rst_n = 0; cyc = 0; stb = 0; we = 0; addr = 0; wdat = 0; sel = 0; irq = 4'b0110;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'b0, ack}, 0);
    chk("rst_data", rdat, 0);
    chk("rst_irq", {31'b0, irq_o}, 0);
    @(negedge clk) rst_n = 1;
    add(0, IMR, 0, 'hF, 4'b0110, 2, 0, 0);
    add(0, ISR, 0, 'hF, 4'b0110, 1, 0, 0);
    add(1, IER, 'hF, 'hF, 4'b0110, 0, 0, 0);
    add(0, IMR, 0, 'hF, 4'b0110, 0, 0, 'hF);
    add(0, ISR, 0, 'hF, 4'b0111, 5, 1, 'h1);
    add(1, ISR, 'h1, 'hF, 4'b0111, 0, 1, 0);
    add(0, ISR, 0, 'hF, 4'b0111, 3, 0, 0);
    add(0, ISR, 0, 'hF, 4'b0101, 5, 1, 'h2);
    add(1, ISR, 'h2, 'hF, 4'b0101, 0, 1, 0);
    add(0, ISR, 0, 'hF, 4'b0101, 100, 0, 0);
    add(0, ISR, 0, 'hF, 4'b0001, 5, 1, 'h4);
    add(1, ISR, 'h4, 'hF, 4'b0001, 0, 1, 0);
    add(0, ISR, 0, 'hF, 4'b0001, 3, 1, 'h4);
    add(1, ISR, 'h4, 'hF, 4'b0101, 4, 1, 0);
    add(0, ISR, 0, 'hF, 4'b0101, 3, 0, 0);
    add(0, ISR, 0, 'hF, 4'b1101, 5, 1, 'h8);
    add(1, ISR, 'h8, 'hF, 4'b1101, 0, 1, 0);
    add(0, ISR, 0, 'hF, 4'b1101, 3, 1, 'h8);
    add(1, ISR, 'h8, 'hF, 4'b0101, 4, 1, 0);
    add(0, ISR, 0, 'hF, 4'b0101, 3, 0, 0);
    add(1, IDR, 'hF, 'hF, 4'b0110, 4, 0, 0);
    add(0, IMR, 0, 'hF, 4'b0110, 0, 0, 0);
    add(0, ISR, 0, 'hF, 4'b1001, 5, 0, 0);
    add(1, IER, 'hF, 'hF, 4'b0110, 5, 0, 0);
    add(0, ISR, 0, 'hF, 4'b0110, 4, 0, 0);
    add(1, IDR, 'h3, 'hF, 4'b0110, 0, 0, 0);
    add(1, IER, 'hF, 'h0, 4'b0110, 0, 0, 0);
    add(0, IMR, 0, 'hF, 4'b0110, 0, 0, 'hC);
    add(1, IER, 'hFFFF_FF01, 'hE, 4'b0110, 0, 0, 0);
    add(0, IMR, 0, 'hF, 4'b0110, 0, 0, 'hC);
    add(1, IER, 'h1, 'hF, 4'b0110, 0, 0, 0);
    add(0, IMR, 0, 'hF, 4'b0110, 0, 0, 'hD);
    add(0, IDR, 0, 'hF, 4'b0110, 0, 0, 0);
    add(0, IER, 0, 'hF, 4'b0110, 0, 0, 0);
    add(1, IER, 'hF, 'hF, 4'b0110, 0, 0, 0);
    add(0, IMR, 0, 'hF, 4'b0110, 4, 0, 'hF);
    foreach (tv[i]) begin
      irq = tv[i].irq;
      repeat (tv[i].w) @(posedge clk);
      #1;
      chk($sformatf("v%0d_irq", i), {31'b0, irq_o}, {31'b0, tv[i].eirq});
      bus(tv[i].we, tv[i].a, tv[i].d, tv[i].s, rd);
      if (!tv[i].we) chk($sformatf("v%0d_rd", i), rd, tv[i].erd);
    end
    @(negedge clk) irq = 4'b0111;
    repeat (3) @(posedge clk);
    #1;
    chk("lat_e2", {31'b0, irq_o}, 0);
    @(posedge clk); #1;
    chk("lat_e3", {31'b0, irq_o}, 1);
    bus(0, ISR, 0, 'hF, rd);
    chk("lat_isr", rd, 'h1);
    bus(1, ISR, 'h1, 'hF, rd);
    chk("clr_irq", {31'b0, irq_o}, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("no_reassert", {31'b0, irq_o}, 0);
    @(negedge clk);
    cyc = 1; stb = 1; we = 0; addr = ISR;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("ack_pulse%0d", i), {31'b0, ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    cyc = 0; stb = 0;
    irq = 4'b0110;
    repeat (4) @(posedge clk);
    bus(0, ISR, 0, 'hF, rd);
    chk("race_pre", rd, 0);
    @(negedge clk) irq = 4'b0111;
    @(negedge clk);
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; addr = ISR; wdat = 'h1; sel = 'hF;
    @(posedge clk); #1;
    chk("race_ack", {31'b0, ack}, 1);
    cyc = 0; stb = 0; we = 0;
    bus(0, ISR, 0, 'hF, rd);
    chk("race_isr", rd, 'h1);
    chk("race_irq", {31'b0, irq_o}, 1);
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; addr = IER; wdat = 'hF; sel = 'hF;
    @(posedge clk); #1;
    chk("rst_acc_ack", {31'b0, ack}, 1);
    rst_n = 0;
    #1;
    chk("rst_mid_ack", {31'b0, ack}, 0);
    chk("rst_mid_irq", {31'b0, irq_o}, 0);
    cyc = 0; stb = 0; we = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    bus(0, IMR, 0, 'hF, rd);
    chk("rst_imr", rd, 0);
    bus(0, ISR, 0, 'hF, rd);
    chk("rst_isr", rd, 0);
    chk("rst_irq_after", {31'b0, irq_o}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
